// File: rtl/arbiter_wrr_lock.sv
// Weighted round-robin arbiter with per-packet grant lock.
// Combinational grant from requests and registered turn/lock state.
module arbiter_wrr_lock #(
  parameter int REQUESTER_COUNT     = 4,
  parameter int LOG_REQUESTER_COUNT = $clog2(REQUESTER_COUNT),
  parameter int WEIGHT_WIDTH        = 4
) (
  input  logic                                    CLK,
  input  logic                                    nRST,
  input  logic [REQUESTER_COUNT-1:0]              req_vec,
  input  logic [REQUESTER_COUNT-1:0]              req_last_vec,
  input  logic [REQUESTER_COUNT*WEIGHT_WIDTH-1:0] weight_by_req,
  input  logic                                    ack_ready,
  output logic                                    ack_valid,
  output logic [REQUESTER_COUNT-1:0]              ack_one_hot,
  output logic [LOG_REQUESTER_COUNT-1:0]          ack_index,
  output logic                                    locked
);

  localparam int N  = REQUESTER_COUNT;
  localparam int L  = LOG_REQUESTER_COUNT;
  localparam int WW = WEIGHT_WIDTH;

  typedef logic [L-1:0]  idx_t;
  typedef logic [WW-1:0] wt_t;

  idx_t rr_ptr_q, rr_ptr_d;
  idx_t lock_index_q, lock_index_d;
  wt_t  credit_count_q, credit_count_d;
  logic lock_valid_q, lock_valid_d;

  logic        gnt_valid;
  idx_t        gnt_idx;
  logic [L:0]  scan;
  logic        gnt_last;
  wt_t         gnt_weight;
  wt_t         cur_credit;
  logic [WW:0] credit_inc;
  logic [WW:0] weight_eff;
  logic        accept;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    if (lock_valid_q) begin
      gnt_valid = req_vec[lock_index_q];
      gnt_idx   = lock_index_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        scan = {1'b0, rr_ptr_q} + (L+1)'(k);
        if (scan >= (L+1)'(N)) scan = scan - (L+1)'(N);
        if (!gnt_valid && req_vec[scan[L-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = scan[L-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt_last   = req_last_vec[gnt_idx];
    gnt_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == idx_t'(i)) gnt_weight = weight_by_req[i*WW +: WW];
    end
    // A stolen turn starts fresh; the idle owner's credit is dropped.
    cur_credit = (gnt_idx == rr_ptr_q) ? credit_count_q : '0;
    weight_eff = (gnt_weight == '0) ? (WW+1)'(1) : {1'b0, gnt_weight};
    credit_inc = {1'b0, cur_credit} + (WW+1)'(1);
  end

  assign accept = gnt_valid & ack_ready;

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    credit_count_d = credit_count_q;
    lock_valid_d   = lock_valid_q;
    lock_index_d   = lock_index_q;
    if (accept) begin
      if (!gnt_last) begin
        lock_valid_d = 1'b1;
        lock_index_d = gnt_idx;
      end else begin
        lock_valid_d = 1'b0;
        if (credit_inc < weight_eff) begin
          rr_ptr_d       = gnt_idx;
          credit_count_d = credit_inc[WW-1:0];
        end else begin
          rr_ptr_d       = (gnt_idx == idx_t'(N-1)) ? '0 : gnt_idx + idx_t'(1);
          credit_count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q       <= '0;
      credit_count_q <= '0;
      lock_valid_q   <= 1'b0;
      lock_index_q   <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      credit_count_q <= credit_count_d;
      lock_valid_q   <= lock_valid_d;
      lock_index_q   <= lock_index_d;
    end
  end

  always_comb begin
    ack_one_hot = '0;
    for (int i = 0; i < N; i++) begin
      ack_one_hot[i] = gnt_valid && (gnt_idx == idx_t'(i));
    end
  end

  assign ack_valid = gnt_valid;
  assign ack_index = gnt_valid ? gnt_idx : '0;
  assign locked    = lock_valid_q;

  // A stalled grantee must hold its request and last flag.
  a_hold_stalled : assert property (
    @(posedge CLK) disable iff (!nRST)
    (ack_valid && !ack_ready) |=>
      ((req_vec & $past(ack_one_hot)) == $past(ack_one_hot)) &&
      (((req_last_vec ^ $past(req_last_vec)) & $past(ack_one_hot)) == '0)
  );

endmodule

// File: doc/arbiter_wrr_lock.md
# arbiter_wrr_lock

Parametrised weighted round-robin arbiter with packet lock, for shared-resource arbitration where requesters issue multi-beat packets and need unequal bandwidth shares (e.g. memory-request muxing between fetch, load/store and prefetch channels). It succeeds the single-beat round-robin arbiter and adds three things:
- per-requester weights, counted in packets per turn;
- a grant lock held from the first to the last beat of a packet;
- a downstream ready handshake.

The grant is combinational from the requests and the registered arbitration state.

## Interface
- REQUESTER_COUNT, default 4: number of requesters; any value ≥ 2, not required to be a power of two.
- LOG_REQUESTER_COUNT, default $clog2(REQUESTER_COUNT): index width.
- WEIGHT_WIDTH, default 4: width of each weight and of the credit counter.

Clock and reset: one clock, CLK; reset nRST, asynchronous, active-low.

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- req_vec  input  REQUESTER_COUNT  per-requester beat request.
- req_last_vec  input  REQUESTER_COUNT  the requester's current beat is the last of its packet. Single-beat packets assert it on their only beat.
- weight_by_req  input  REQUESTER_COUNT×WEIGHT_WIDTH  packets per turn for each requester. A weight of 0 is treated as 1.
- ack_ready  input  1  downstream accepts the granted beat this cycle.
- ack_valid  output  1  a grant is issued this cycle.
- ack_one_hot  output  REQUESTER_COUNT  granted requester, one-hot; all zero when ack_valid=0.
- ack_index  output  LOG_REQUESTER_COUNT  granted requester index; 0 when ack_valid=0.
- locked  output  1  arbiter is mid-packet (lock_valid).

## Operation
State registers:
- rr_ptr: turn owner, the highest-priority index.
- credit_count: packets already granted to rr_ptr in its current turn.
- lock_valid, lock_index.

Grant selection:
- **Unlocked:** grant the first i with req_vec[i]=1, scanning rr_ptr, rr_ptr+1, … modulo REQUESTER_COUNT.
- **Locked:** grant lock_index only if req_vec[lock_index]=1; otherwise ack_valid=0. No other requester is ever granted while locked.

A beat is accepted when ack_valid & ack_ready. Let i be the granted index.

Accepted beat with req_last_vec[i]=0 (packet continues):
- lock_valid←1, lock_index←i.
- rr_ptr and credit_count are unchanged.

Accepted beat with req_last_vec[i]=1 (packet complete):
- lock_valid←0.
- Let c = credit_count if i==rr_ptr, else 0. Let w = max(weight_by_req[i], 1).
- If c+1 < w: rr_ptr←i, credit_count←c+1.
- Else: rr_ptr←(i+1) mod REQUESTER_COUNT, credit_count←0. The index REQUESTER_COUNT−1 wraps to 0.

Other cases:
- No accepted beat: all state holds.
- Weight changes apply at the next packet-completion evaluation. credit_count is not re-clamped to a new, smaller weight; the c+1<w test handles that case.
- When a lower-priority requester is granted because rr_ptr is idle, that requester starts its own turn (c=0). Credit the idle owner had is discarded.

Requester rules (protocol assumptions, checked by assertions):
- Once granted with ack_ready=0, a requester holds req_vec and req_last_vec stable until accepted.
- A locked requester keeps requesting until its last beat. If it drops its request, the arbiter stalls with ack_valid=0; there is no lock timeout.

## Timing
- Grant outputs are combinational from req_vec, req_last_vec-independent selection and the registered state. The grant is valid in the same cycle as the request, i.e. zero-cycle latency.
- State updates at posedge CLK on accepted beats only. A new turn owner or lock affects the grant in the cycle after acceptance.
- Unlocked with ack_ready=0: the grant may move if req_vec changes. Locked: the grant is pinned to lock_index.
- Back-to-back packets with ready=1 sustain one beat per cycle with no bubbles, including across lock release and turn change.
- Reset, asynchronous and allowed at any time including mid-packet, sets rr_ptr=0, credit_count=0, lock_valid=0, lock_index=0.
- Under reset: locked=0; with req_vec=0, ack_valid=0, ack_one_hot=0, ack_index=0. Outputs follow the rules above from the first cycle after nRST deasserts.

## Test plan
- **Plain round-robin:** REQUESTER_COUNT=4, all weights 1, req_vec=4'b1111, req_last_vec=4'b1111, ready=1 for 5 cycles → ack_index 0,1,2,3,0.
- **Weighted:** weights {0:3,1:1,2:0,3:1}, all requesting single-beat packets, ready=1 → ack_index 0,0,0,1,2,3,0,0,0. The weight 0 on requester 2 behaves as 1.
- **Lock and backpressure:**
  - Setup: req_vec=4'b0011; requester 0 sends a 3-beat packet (last on beat 3); ready pattern 1,0,1,1.
  - Required: ack_index 0 on all four cycles; locked=1 from after beat 1 until after beat 3; requester 1 granted on cycle 5.
  - Variant: drop req 0 mid-lock → ack_valid=0 and locked stays 1.
- **Skip and wrap:**
  - Setup: rr_ptr=0; only requester 2 requests, weight 2, two single-beat packets.
  - Required: grants 2,2.
  - Then req_vec=4'b1111 → first grant 3, next 0.
- **Non-power-of-two count:** REQUESTER_COUNT=3, all requesting, weight 1 → ack_index 0,1,2,0. ack_index never reaches 3.
- **Reset mid-packet:**
  - Setup: requester 2 locked with rr_ptr=2; pulse nRST low asynchronously.
  - Required: locked drops immediately. After release with req_vec=4'b0110, the grant goes to 1 (rr_ptr=0).
